// File: rtl/candidate_generator.sv
// Base-36 candidate sweeper: walks {from,0..0} through {to,Z..Z} as ASCII words over a
// valid/ready handshake, with abort, done pulse and a transferred-candidate counter.
module candidate_generator #(
   parameter int unsigned LEN   = 4,
   parameter int unsigned CNT_W = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       from,
   input  logic [5:0]       to,
   input  logic             stop,
   output logic             cand_valid,
   input  logic             cand_ready,
   output logic [8*LEN-1:0] cand_data,
   output logic             busy,
   output logic             done,
   output logic             exhausted,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e                r_state, w_state_next;
   logic [LEN-1:0][5:0]   r_dig, w_dig_next, w_dig_inc;
   logic [5:0]            r_to, w_to_next;
   logic [CNT_W-1:0]      r_count, w_count_next;
   logic                  r_exhausted, w_exh_next;
   logic                  w_xfer;
   logic                  w_last;
   logic                  w_carry;

   assign cand_valid = (r_state == StRun);
   assign busy       = (r_state == StRun);
   assign done       = (r_state == StFin);
   assign exhausted  = r_exhausted;
   assign count      = r_count;
   assign w_xfer     = cand_valid & cand_ready;

   // Ripple increment with d[LEN-1] as the least significant digit.
   always_comb begin
      w_dig_inc = r_dig;
      w_carry   = 1'b1;
      for (int i = int'(LEN) - 1; i >= 0; i--) begin
         if (w_carry) begin
            if (r_dig[i] == 6'd35) begin
               w_dig_inc[i] = 6'd0;
            end else begin
               w_dig_inc[i] = r_dig[i] + 6'd1;
               w_carry      = 1'b0;
            end
         end
      end
   end

   always_comb begin
      w_last = (r_dig[0] == r_to);
      for (int i = 1; i < int'(LEN); i++) begin
         w_last = w_last & (r_dig[i] == 6'd35);
      end
   end

   always_comb begin
      cand_data = '0;
      for (int i = 0; i < int'(LEN); i++) begin
         if (r_dig[i] < 6'd10) begin
            cand_data[8*(int'(LEN)-1-i) +: 8] = 8'h30 + {2'b00, r_dig[i]};
         end else begin
            cand_data[8*(int'(LEN)-1-i) +: 8] = 8'h37 + {2'b00, r_dig[i]};
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_dig_next   = r_dig;
      w_to_next    = r_to;
      w_count_next = r_count;
      w_exh_next   = r_exhausted;
      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_count_next = '0;
               w_to_next    = to;
               if ((from <= to) && (to <= 6'd35)) begin
                  w_dig_next    = '0;
                  w_dig_next[0] = from;
                  w_exh_next    = 1'b0;
                  w_state_next  = StRun;
               end else begin
                  w_exh_next   = 1'b1;
                  w_state_next = StFin;
               end
            end
         end
         StRun: begin
            if (w_xfer) begin
               w_count_next = r_count + CNT_W'(1);
               if (!stop) begin
                  if (w_last) begin
                     w_exh_next   = 1'b1;
                     w_state_next = StFin;
                  end else begin
                     w_dig_next = w_dig_inc;
                  end
               end
            end
            // An abort wins over reaching the last candidate.
            if (stop) begin
               w_exh_next   = 1'b0;
               w_state_next = StFin;
            end
         end
         StFin: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_dig       <= '0;
         r_to        <= '0;
         r_count     <= '0;
         r_exhausted <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_dig       <= w_dig_next;
         r_to        <= w_to_next;
         r_count     <= w_count_next;
         r_exhausted <= w_exh_next;
      end
   end

endmodule

// File: tb/tb_candidate_generator.sv
// Scoreboard bench for candidate_generator: a driver queues expected candidates and sweep
// results from an arithmetic base-36 model; a negedge monitor checks whatever the DUT shows.
module tb_candidate_generator;

   localparam int unsigned LEN   = 4;
   localparam int unsigned CNT_W = 21;
   localparam int unsigned SPAN  = 36 ** (LEN - 1);

   typedef struct {
      int unsigned cnt;
      bit          exh;
   } end_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [5:0]       from = '0;
   logic [5:0]       to = '0;
   logic             stop = 1'b0;
   logic             cand_valid;
   logic             cand_ready = 1'b0;
   logic [8*LEN-1:0] cand_data;
   logic             busy;
   logic             done;
   logic             exhausted;
   logic [CNT_W-1:0] count;

   logic [8*LEN-1:0] exp_q[$];
   end_t             end_q[$];
   int               n_pass  = 0;
   int               n_total = 0;

   candidate_generator #(.LEN(LEN), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .from       (from),
      .to         (to),
      .stop       (stop),
      .cand_valid (cand_valid),
      .cand_ready (cand_ready),
      .cand_data  (cand_data),
      .busy       (busy),
      .done       (done),
      .exhausted  (exhausted),
      .count      (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Candidate number idx of the full space, as ASCII with the first character on top.
   function automatic logic [8*LEN-1:0] model_cand(input int unsigned idx);
      logic [8*LEN-1:0] s;
      int unsigned      v;
      int unsigned      dg;
      v = idx;
      s = '0;
      for (int i = 0; i < int'(LEN); i++) begin
         dg = v % 36;
         v  = v / 36;
         s[8*i +: 8] = (dg < 10) ? 8'(48 + dg) : 8'(55 + dg);
      end
      return s;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (cand_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_cand", {32'd0, cand_data}, 64'd0);
            end else begin
               check("cand_data", {32'd0, cand_data}, {32'd0, exp_q[0]});
               if (cand_ready) void'(exp_q.pop_front());
            end
         end
         if (done) begin
            if (end_q.size() == 0) begin
               check("unexpected_done", 64'(done), 64'd0);
            end else begin
               end_t e;
               e = end_q.pop_front();
               check("end_count", 64'(count), 64'(e.cnt));
               check("end_exhausted", 64'(exhausted), 64'(e.exh));
               check("end_leftover", 64'(exp_q.size()), 64'd0);
            end
         end
      end
   end

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, 64'(cand_valid), 64'd0);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_exhausted"}, 64'(exhausted), 64'd0);
      check({tag, "_count"}, 64'(count), 64'd0);
      check({tag, "_data"}, {32'd0, cand_data}, {32'd0, model_cand(0)});
   endtask

   // mode: 0 ready always, 1 random ready, 2 ready pattern 1,0,0,1,1...
   // stop_at: pulse stop with the stop_at-th transfer (0 = never).
   task automatic run_sweep(input int f, input int t, input int stop_at, input int mode,
                            input int restart_at);
      bit          ok_range;
      int unsigned total, n, xfers, cyc, budget;
      bit          exh, r, xfer_now;
      end_t        e;
      ok_range = (f <= t) && (t <= 35);
      if (ok_range) begin
         total = (t - f + 1) * SPAN;
         if (stop_at > 0 && stop_at <= int'(total)) begin
            n   = stop_at;
            exh = 1'b0;
         end else begin
            n   = total;
            exh = 1'b1;
         end
      end else begin
         n   = 0;
         exh = 1'b1;
      end
      for (int unsigned k = 0; k < n; k++) exp_q.push_back(model_cand(f * SPAN + k));
      e.cnt = n;
      e.exh = exh;
      end_q.push_back(e);

      @(posedge clk); #1;
      start = 1'b1;
      from  = 6'(f);
      to    = 6'(t);
      @(posedge clk); #1;
      start = 1'b0;
      if (!ok_range) begin
         check("bad_range_done", 64'(done), 64'd1);
         check("bad_range_valid", 64'(cand_valid), 64'd0);
      end else begin
         check("valid_after_start", 64'(cand_valid), 64'd1);
         check("busy_after_start", 64'(busy), 64'd1);
         xfers  = 0;
         cyc    = 0;
         budget = 8 * n + 100;
         do begin
            case (mode)
               0:       r = 1'b1;
               1:       r = 1'($urandom_range(0, 1));
               default: r = !(cyc == 1 || cyc == 2);
            endcase
            cand_ready = r;
            stop = (stop_at > 0) && r && cand_valid && (xfers == stop_at - 1);
            if (int'(cyc) == restart_at) begin
               start = 1'b1;
               from  = 6'd0;
               to    = 6'd0;
            end else begin
               start = 1'b0;
            end
            xfer_now = cand_valid && r;
            @(posedge clk); #1;
            if (xfer_now) xfers++;
            cyc++;
         end while (!done && cyc < budget);
         check("done_seen", 64'(done), 64'd1);
         start      = 1'b0;
         stop       = 1'b0;
         cand_ready = 1'b0;
      end
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'd0);
      check("idle_hold_count", 64'(count), 64'(n));
      check("idle_hold_exhausted", 64'(exhausted), 64'(exh));
   endtask

   initial begin
      int dcount;
      int f;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      run_sweep(0, 0, 0, 0, -1);    // whole first-character-0 space
      run_sweep(0, 35, 2, 0, -1);   // abort with "0001"
      run_sweep(0, 35, 6, 2, -1);   // stall on "0001"
      run_sweep(5, 3, 0, 0, -1);    // from > to
      run_sweep(3, 36, 0, 0, -1);   // to out of range
      run_sweep(7, 9, 40, 1, 5);    // start during RUN must be ignored
      for (int i = 0; i < 3; i++) begin
         f = $urandom_range(0, 35);
         run_sweep(f, $urandom_range(f, 35), $urandom_range(1, 200), 1, -1);
      end

      // Asynchronous reset in the middle of a sweep.
      for (int unsigned k = 0; k < 50; k++) exp_q.push_back(model_cand(SPAN + k));
      @(posedge clk); #1;
      start = 1'b1;
      from  = 6'd1;
      to    = 6'd2;
      @(posedge clk); #1;
      start      = 1'b0;
      cand_ready = 1'b1;
      repeat (8) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_reset_values("midreset");
      exp_q.delete();
      cand_ready = 1'b0;
      @(posedge clk); #2;
      rst    = 1'b0;
      dcount = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      check("no_done_after_reset", 64'(dcount), 64'd0);

      run_sweep(35, 35, 3, 0, -1);  // recovery after reset
      repeat (3) @(posedge clk);
      check("final_exp_queue", 64'(exp_q.size()), 64'd0);
      check("final_end_queue", 64'(end_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/candidate_generator.md
CANDIDATE_GENERATOR -- requirements
Module: candidate_generator

Interface
REQ-001 SHALL have parameter LEN, default 4, meaning number of characters per candidate.
REQ-002 SHALL have parameter CNT_W, default 21, meaning width of the transferred-candidate counter; it SHALL be at least ceil(log2(36^LEN + 1)).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a sweep.
REQ-006 SHALL have port from  input  6  first-character index, lower bound, inclusive; sampled on start.
REQ-007 SHALL have port to  input  6  first-character index, upper bound, inclusive; sampled on start.
REQ-008 SHALL have port stop  input  1  abort request from the downstream comparator (its found).
REQ-009 SHALL have port cand_valid  output  1  cand_data holds a valid candidate.
REQ-010 SHALL have port cand_ready  input  1  downstream accepts the candidate.
REQ-011 SHALL have port cand_data  output  8*LEN  ASCII candidate; character 0 (most significant digit) in the top byte.
REQ-012 SHALL have port busy  output  1  high while in state RUN.
REQ-013 SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-014 SHALL have port exhausted  output  1  last sweep ended without stop; held until next accepted start.
REQ-015 SHALL have port count  output  CNT_W  number of candidates transferred in the current or last sweep.

Function
REQ-016 SHALL keep LEN base-36 digit registers d[0..LEN-1], with d[0] most significant.
REQ-017 SHALL map each digit combinationally to cand_data: 0-9 -> 0x30-0x39 and 10-35 -> 0x41-0x5A.
REQ-018 SHALL implement states IDLE, RUN and FIN.
REQ-019 In IDLE with start=1 and from<=to<=35, SHALL load d={from,0,...,0}, clear count and exhausted, and enter RUN; cand_valid SHALL be 1 in the next cycle.
REQ-020 In IDLE with start=1 and (from>to or to>35), SHALL emit no candidate, set exhausted=1, clear count and enter FIN.
REQ-021 SHALL ignore start in RUN and FIN.
REQ-022 In RUN, cand_valid SHALL be 1 and cand_data SHALL stay stable until a transfer (cand_valid and cand_ready both high).
REQ-023 On each transfer, SHALL increment count by 1 and increment d as a base-36 counter, d[LEN-1] least significant, with digit 35 wrapping to 0 and carrying upward.
REQ-024 On a transfer of {to,35,...,35}, SHALL set exhausted=1 and enter FIN; no digit increment is needed past the last candidate.
REQ-025 In RUN with stop=1, SHALL enter FIN with exhausted=0; cand_valid SHALL be 0 from the next cycle.
REQ-026 When stop=1 and a transfer occur in the same cycle, SHALL count that transfer and enter FIN with exhausted=0, even if it was the last candidate.
REQ-027 In FIN, SHALL assert done for exactly one cycle and then return to IDLE.
REQ-028 SHALL keep cand_valid=0 in IDLE and FIN.
REQ-029 SHALL assert busy only in RUN.
REQ-030 SHALL hold count and exhausted in IDLE until the next accepted start.
REQ-031 SHALL NOT wrap count, because the maximum sweep is 36^LEN transfers.
REQ-032 SHALL treat from=to as a valid single-first-character sweep of 36^(LEN-1) candidates.

Reset
REQ-033 On rst=1, SHALL immediately, without waiting for clk, enter IDLE with cand_valid=0, busy=0, done=0, exhausted=0, count=0 and all d=0, so cand_data reads "0000" for LEN=4.
REQ-034 Reset asserted in mid-sweep SHALL abandon the sweep, produce no done pulse, and require a new start.
REQ-035 Release of rst SHALL take effect on the next rising clk edge.

Verification
REQ-036 SHALL pass: start, from=0, to=0, cand_ready=1 -> first cand_data "0000" one cycle after start; sequence "0001".."0009","000A"; "00ZZ" followed by "0100"; last "0ZZZ"; count=46656, done pulse, exhausted=1.
REQ-037 SHALL pass: from=0, to=35, stop pulsed in the cycle "0001" transfers -> count=2, cand_valid=0 next cycle, done pulse, exhausted=0.
REQ-038 SHALL pass: cand_ready toggled 1,0,0,1 -> cand_data held at "0001" through the stall; no candidate skipped or duplicated.
REQ-039 SHALL pass: from=5, to=3 -> no cand_valid, done one cycle after start, exhausted=1, count=0; repeat with to=36 gives the same result.
REQ-040 SHALL pass: start pulsed again during RUN -> ignored, sequence continues unchanged.
REQ-041 SHALL pass: rst asserted between clk edges mid-sweep -> outputs reach reset values immediately; no done pulse follows.
